spi_master_burst: RTL and testbench
===================================

Name: spi_master_burst

Overview:
- Next-generation SPI master, generalised from the single-word, single-slave, fixed-mode master.
- Adds parametrised word width and chip-select count, runtime SPI mode, runtime bit order, wider clock divider, and multi-word bursts with SS held asserted.
- Sits between a local controller and up to NUM_SS off-chip SPI slaves.
- Words stream in over a valid/ready handshake; received words stream out as one-cycle strobes.

Parameters:
- DATA_WIDTH, 8: bits per SPI word.
- NUM_SS, 4: number of active-low slave selects.
- SEL_WIDTH, 2: width of SlaveSel; must satisfy 2^SEL_WIDTH >= NUM_SS.
- DIV_WIDTH, 4: width of ClkDiv.
- LEN_WIDTH, 8: width of BurstLen.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle request; sampled only in IDLE.
- SlaveSel  in  SEL_WIDTH  target slave index; latched on Start.
- Mode  in  2  {CPOL,CPHA}; latched on Start.
- LsbFirst  in  1  1 = LSB shifted first; latched on Start.
- ClkDiv  in  DIV_WIDTH  SClk half-period = ClkDiv+1 Clk cycles; latched on Start.
- BurstLen  in  LEN_WIDTH  words in burst; 0 treated as 1; latched on Start.
- TxData  in  DATA_WIDTH  transmit word; first word captured with Start.
- TxValid  in  1  next burst word available on TxData.
- TxReady  out  1  master accepts TxData this cycle when TxValid=1.
- RxData  out  DATA_WIDTH  last received word.
- RxValid  out  1  one-cycle strobe; RxData updated this cycle.
- Busy  out  1  high from the cycle after accepted Start until Done.
- Done  out  1  one-cycle pulse at burst end.
- MISO  in  1  serial data from slave.
- SClk  out  1  SPI clock.
- MOSI  out  1  serial data to slave.
- SS  out  NUM_SS  active-low selects; at most one bit low.

Behaviour:
- Reset values: SS all ones, SClk 0, MOSI 0, TxReady 0, RxValid 0, RxData 0, Busy 0, Done 0; state IDLE.
- Reset mid-burst aborts immediately. SS deasserts the next edge. No Done, no RxValid.
- IDLE:
  - SClk is driven to registered Mode[1] each cycle.
  - Start with SlaveSel < NUM_SS: latch config, latch TxData, go to SETUP.
  - Start with SlaveSel >= NUM_SS: ignored; no Busy, no Done.
- SETUP:
  - SS[SlaveSel] low; SClk at CPOL.
  - For CPHA=0, MOSI presents the first bit.
  - Lasts one half-period, then XFER.
- XFER:
  - 2*DATA_WIDTH SClk edges, one per half-period.
  - CPHA=0: sample MISO on leading edges; shift MOSI on trailing edges, except after the final bit.
  - CPHA=1: shift MOSI on leading edges; sample MISO on trailing edges.
  - Bit order follows LsbFirst for both directions.
  - After the last edge, RxData is loaded and RxValid pulses one cycle.
  - Then go to GAP if words remain, else HOLD.
- GAP:
  - SClk idles at CPOL and SS stays low.
  - TxReady=1 until a word is captured (TxValid&&TxReady). TxReady drops the cycle after capture.
  - Minimum duration is one half-period; the state stalls indefinitely while no word has been captured.
  - Exit to XFER after the half-period has elapsed and a word is held. For CPHA=0, MOSI presents the first bit on exit.
- HOLD:
  - SS low, SClk at CPOL, for one half-period.
  - Then SS deasserts, Done pulses in the same cycle as the SS rise, Busy drops, state returns to IDLE.
- Start while Busy is ignored.
- TxValid outside GAP is ignored.
- ClkDiv=0 gives SClk = Clk/2. Maximum half-period is 2^DIV_WIDTH cycles.
- Word counter decrements per completed word. Burst of BurstLen=255 must not wrap.
- Single-word burst (BurstLen 0 or 1) never enters GAP and never asserts TxReady.

Test Plan:
- Mode 3, ClkDiv=1, SlaveSel=0, BurstLen=1, TxData=A5, loopback slave returns D6 -> SS[0] low for 1 burst, 8 SClk pulses, RxData=D6 with one RxValid, Done one pulse, MOSI stream 1010_0101 MSB first.
- All four Modes × LsbFirst 0/1, TxData=3C, slave returns C3 -> correct edge alignment and bit order, RxData=C3 each case.
- BurstLen=4, SlaveSel=2, TxValid held high with 11,22,33,44 -> SS[2] continuously low, 4 RxValid strobes, exactly 3 TxReady captures, single Done.
- BurstLen=3, TxValid withheld 20 cycles at first GAP -> SClk idle at CPOL, SS held low, transfer resumes correctly, no extra SClk edges.
- Reset asserted mid-XFER of a 2-word burst -> next cycle SS=all ones, Busy=0, no Done or RxValid. A new Start then completes normally.
- SlaveSel=5 (NUM_SS=4) with Start -> no SS activity, Busy stays 0, Done never pulses. Start during Busy has no effect.

Source files
------------

// File: rtl/spi_master_burst.sv
// SPI master with runtime mode, bit order and clock divider. It runs multi-word bursts
// with SS held low and streams received words out as one-cycle RxValid strobes.
module spi_master_burst #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SS     = 4,
   parameter int SEL_WIDTH  = 2,
   parameter int DIV_WIDTH  = 4,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [SEL_WIDTH-1:0]  SlaveSel,
   input  logic [1:0]            Mode,
   input  logic                  LsbFirst,
   input  logic [DIV_WIDTH-1:0]  ClkDiv,
   input  logic [LEN_WIDTH-1:0]  BurstLen,
   input  logic [DATA_WIDTH-1:0] TxData,
   input  logic                  TxValid,
   output logic                  TxReady,
   output logic [DATA_WIDTH-1:0] RxData,
   output logic                  RxValid,
   output logic                  Busy,
   output logic                  Done,
   input  logic                  MISO,
   output logic                  SClk,
   output logic                  MOSI,
   output logic [NUM_SS-1:0]     SS
);

   localparam int EW = $clog2(2 * DATA_WIDTH);
   localparam int BW = EW - 1;
   localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
   localparam int unsigned   NSS       = NUM_SS;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_GAP, S_HOLD} state_t;

   state_t                state_q, state_d;
   logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
   logic [DIV_WIDTH-1:0]  clk_div_q, clk_div_d;
   logic [EW-1:0]         edge_q, edge_d;
   logic [LEN_WIDTH-1:0]  words_q, words_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  sclk_q, sclk_d;
   logic                  mosi_q, mosi_d;
   logic [NUM_SS-1:0]     ss_q, ss_d;
   logic                  have_q, have_d;
   logic                  cpha_q, cpha_d;
   logic                  lsb_q, lsb_d;

   logic                  tick;
   logic                  leading;
   logic                  sel_ok;
   logic [BW-1:0]         bit_num;
   logic [BW-1:0]         bit_nxt;

   function automatic logic [BW-1:0] bit_pos(input logic [BW-1:0] b, input logic lsb);
      return lsb ? b : LAST_BIT - b;
   endfunction

   assign tick    = (div_cnt_q == clk_div_q);
   assign leading = ~edge_q[0];
   assign bit_num = edge_q[EW-1:1];
   assign bit_nxt = bit_num + 1'b1;
   assign sel_ok  = (32'(SlaveSel) < NSS);

   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q;
      clk_div_d  = clk_div_q;
      edge_d     = edge_q;
      words_d    = words_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      done_d     = 1'b0;
      busy_d     = busy_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      ss_d       = ss_q;
      have_d     = have_q;
      cpha_d     = cpha_q;
      lsb_d      = lsb_q;

      unique case (state_q)
         S_IDLE: begin
            sclk_d = Mode[1];
            if (Start && sel_ok) begin
               cpha_d    = Mode[0];
               lsb_d     = LsbFirst;
               clk_div_d = ClkDiv;
               words_d   = (BurstLen == '0) ? LEN_WIDTH'(1) : BurstLen;
               tx_d      = TxData;
               ss_d      = ~({{(NUM_SS-1){1'b0}}, 1'b1} << SlaveSel);
               mosi_d    = Mode[0] ? 1'b0 : TxData[bit_pos('0, LsbFirst)];
               busy_d    = 1'b1;
               div_cnt_d = '0;
               edge_d    = '0;
               have_d    = 1'b0;
               state_d   = S_SETUP;
            end
         end

         S_SETUP: begin
            if (tick) begin
               div_cnt_d = '0;
               state_d   = S_XFER;
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end

         S_XFER: begin
            if (tick) begin
               div_cnt_d = '0;
               sclk_d    = ~sclk_q;
               edge_d    = edge_q + 1'b1;
               // Sampling edge is the leading one for CPHA=0 and the trailing one for CPHA=1.
               if (leading ^ cpha_q) begin
                  rx_d[bit_pos(bit_num, lsb_q)] = MISO;
               end else if (cpha_q) begin
                  mosi_d = tx_q[bit_pos(bit_num, lsb_q)];
               end else if (bit_num != LAST_BIT) begin
                  mosi_d = tx_q[bit_pos(bit_nxt, lsb_q)];
               end
               if (edge_q == LAST_EDGE) begin
                  edge_d     = '0;
                  rx_data_d  = rx_d;
                  rx_valid_d = 1'b1;
                  if (words_q > LEN_WIDTH'(1)) begin
                     words_d = words_q - 1'b1;
                     have_d  = 1'b0;
                     state_d = S_GAP;
                  end else begin
                     state_d = S_HOLD;
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end

         S_GAP: begin
            if (TxValid && !have_q) begin
               tx_d   = TxData;
               have_d = 1'b1;
            end
            // The divider parks at its terminal count until a word is held.
            if (tick) begin
               if (have_q) begin
                  div_cnt_d = '0;
                  have_d    = 1'b0;
                  mosi_d    = cpha_q ? mosi_q : tx_q[bit_pos('0, lsb_q)];
                  state_d   = S_XFER;
               end
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end

         S_HOLD: begin
            if (tick) begin
               div_cnt_d = '0;
               ss_d      = '1;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               mosi_d    = 1'b0;
               state_d   = S_IDLE;
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         div_cnt_q  <= '0;
         clk_div_q  <= '0;
         edge_q     <= '0;
         words_q    <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         ss_q       <= '1;
         have_q     <= 1'b0;
         cpha_q     <= 1'b0;
         lsb_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         clk_div_q  <= clk_div_d;
         edge_q     <= edge_d;
         words_q    <= words_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         ss_q       <= ss_d;
         have_q     <= have_d;
         cpha_q     <= cpha_d;
         lsb_q      <= lsb_d;
      end
   end

   assign TxReady = (state_q == S_GAP) && !have_q;
   assign RxData  = rx_data_q;
   assign RxValid = rx_valid_q;
   assign Busy    = busy_q;
   assign Done    = done_q;
   assign SClk    = sclk_q;
   assign MOSI    = mosi_q;
   assign SS      = ss_q;

endmodule

// File: tb/tb_spi_master_burst.sv
// Bench for spi_master_burst: a behavioural SPI slave plus per-burst expectation arrays,
// driven by randomized and directed bursts.
module tb_spi_master_burst;

   localparam int DW  = 8;
   localparam int NSS = 4;
   localparam int SW  = 3;
   localparam int DVW = 4;
   localparam int LW  = 8;
   localparam int BIW = $clog2(DW);

   logic            Clk = 1'b0;
   logic            Reset, Start, LsbFirst, TxValid;
   logic            MISO = 1'b0;
   logic [SW-1:0]   SlaveSel;
   logic [1:0]      Mode;
   logic [DVW-1:0]  ClkDiv;
   logic [LW-1:0]   BurstLen;
   logic [DW-1:0]   TxData, RxData;
   logic            TxReady, RxValid, Busy, Done, SClk, MOSI;
   logic [NSS-1:0]  SS;

   spi_master_burst #(
      .DATA_WIDTH(DW), .NUM_SS(NSS), .SEL_WIDTH(SW), .DIV_WIDTH(DVW), .LEN_WIDTH(LW)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .SlaveSel(SlaveSel), .Mode(Mode),
      .LsbFirst(LsbFirst), .ClkDiv(ClkDiv), .BurstLen(BurstLen), .TxData(TxData),
      .TxValid(TxValid), .TxReady(TxReady), .RxData(RxData), .RxValid(RxValid),
      .Busy(Busy), .Done(Done), .MISO(MISO), .SClk(SClk), .MOSI(MOSI), .SS(SS)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Burst configuration as seen by the slave model and monitor.
   logic           cur_cpol = 1'b0, cur_cpha = 1'b0, cur_lsb = 1'b0;
   logic [NSS-1:0] exp_ss = '1;
   logic [DW-1:0]  tx_arr [256];
   logic [DW-1:0]  resp_arr [256];

   logic sel_active;
   assign sel_active = (SS != '1);

   function automatic logic [BIW-1:0] bidx(input int k);
      return BIW'(cur_lsb ? k : DW - 1 - k);
   endfunction

   // Behavioural SPI slave: drives resp_arr words, collects MOSI words in mosi_arr.
   logic [DW-1:0] mosi_arr [256];
   logic [DW-1:0] s_out, s_in;
   int            s_bit, s_word, mosi_n, pulses;
   logic          s_prev_sel = 1'b0, s_prev_sclk = 1'b0;

   always @(sel_active or SClk) begin
      if (sel_active && !s_prev_sel) begin
         s_word = 0; mosi_n = 0; pulses = 0; s_bit = 0; s_in = '0;
         s_out  = resp_arr[0];
         MISO   = cur_cpha ? 1'b0 : s_out[bidx(0)];
      end else if (!sel_active && s_prev_sel) begin
         MISO = 1'b0;
      end else if (sel_active && SClk !== s_prev_sclk) begin
         if (SClk !== cur_cpol) begin
            pulses++;
            if (cur_cpha) MISO = s_out[bidx(s_bit)];
            else          s_in[bidx(s_bit)] = MOSI;
         end else begin
            if (cur_cpha) s_in[bidx(s_bit)] = MOSI;
            s_bit++;
            if (s_bit == DW) begin
               if (s_word < 256) mosi_arr[s_word] = s_in;
               s_word++;
               mosi_n = s_word;
               s_bit  = 0;
               s_out  = resp_arr[s_word % 256];
            end
            if (!cur_cpha) MISO = s_out[bidx(s_bit)];
         end
      end
      s_prev_sel  = sel_active;
      s_prev_sclk = SClk;
   end

   // Cycle monitor, sampled on the falling clock edge.
   logic          clr = 1'b0;
   logic          m_prev_sel = 1'b0;
   int            rxv_cnt, done_cnt, cap_cnt, txr_cnt, ss_bad, gap_bad, busy_cnt, ss_fall;
   logic [DW-1:0] rx_obs [$];

   always @(negedge Clk) begin
      if (clr) begin
         rxv_cnt = 0; done_cnt = 0; cap_cnt = 0; txr_cnt = 0;
         ss_bad = 0; gap_bad = 0; busy_cnt = 0; ss_fall = 0;
         rx_obs.delete();
      end else begin
         if (RxValid) begin rxv_cnt++; rx_obs.push_back(RxData); end
         if (Done) done_cnt++;
         if (TxValid && TxReady) cap_cnt++;
         if (TxReady) begin
            txr_cnt++;
            if (SClk !== cur_cpol || SS == '1) gap_bad++;
         end
         if (SS !== '1 && SS !== exp_ss) ss_bad++;
         if (Busy) busy_cnt++;
         if (sel_active && !m_prev_sel) ss_fall++;
      end
      m_prev_sel = sel_active;
   end

   task automatic fill_random();
      for (int i = 0; i < 256; i++) begin
         tx_arr[i]   = DW'($urandom);
         resp_arr[i] = DW'($urandom);
      end
   endtask

   task automatic setup_cfg(input int sel, input int mode, input int lsb, input int div, input int len);
      @(posedge Clk); #1;
      cur_cpol = mode[1]; cur_cpha = mode[0]; cur_lsb = lsb[0];
      exp_ss   = (sel < NSS) ? ~(NSS'(1) << sel) : '1;
      SlaveSel = SW'(sel); Mode = 2'(mode); LsbFirst = lsb[0];
      ClkDiv   = DVW'(div); BurstLen = LW'(len);
      repeat (2) @(posedge Clk);
      #1 clr = 1'b1;
      @(negedge Clk); #1 clr = 1'b0;
   endtask

   task automatic run_burst(input int sel, input int mode, input int lsb, input int div,
                            input int len, input int stall, input bit poke);
      int n, limit, k, waited;
      bit seen_done;
      n = (len == 0) ? 1 : len;
      limit = (n * (2 * DW + 6) + 8) * (div + 2) + stall + 50;
      k = 1; waited = 0; seen_done = 0;
      setup_cfg(sel, mode, lsb, div, len);
      @(posedge Clk); #1;
      Start = 1'b1; TxData = tx_arr[0]; TxValid = (n > 1 && stall == 0);
      @(posedge Clk); #1;
      Start = 1'b0;
      if (TxValid) TxData = tx_arr[1];
      check_eq("busy_after_start", 32'(Busy), 1);
      if (poke) begin
         repeat (3) @(posedge Clk); #1;
         Start = 1'b1; SlaveSel = SW'((sel + 1) % NSS);
         @(posedge Clk); #1;
         Start = 1'b0; SlaveSel = SW'(sel);
      end
      for (int c = 0; c < limit && !seen_done; c++) begin
         @(negedge Clk);
         if (Done) seen_done = 1;
         if (k < n && !TxValid && TxReady) begin
            waited++;
            if (waited > stall) begin TxValid = 1'b1; TxData = tx_arr[k]; end
         end
         if (k < n && TxValid && TxReady) begin
            @(posedge Clk); #1;
            k++;
            if (k < n) TxData = tx_arr[k];
            else begin TxValid = 1'b0; TxData = '0; end
         end
      end
      check_eq("done_seen", 32'(seen_done), 1);
      repeat (3) @(negedge Clk);
      check_eq("done_cnt", done_cnt, 1);
      check_eq("rxvalid_cnt", rxv_cnt, n);
      check_eq("sclk_pulses", pulses, n * DW);
      check_eq("tx_captures", cap_cnt, n - 1);
      check_eq("ss_fall", ss_fall, 1);
      check_eq("ss_bad", ss_bad, 0);
      check_eq("gap_idle", gap_bad, 0);
      check_eq("mosi_words", mosi_n, n);
      if (n == 1) check_eq("txready_single", txr_cnt, 0);
      for (int i = 0; i < n; i++) begin
         check_eq($sformatf("rxdata[%0d]", i),
                  32'((i < rx_obs.size()) ? rx_obs[i] : 'x), 32'(resp_arr[i]));
         check_eq($sformatf("mosi[%0d]", i), 32'(mosi_arr[i]), 32'(tx_arr[i]));
      end
      check_eq("busy_end", 32'(Busy), 0);
      check_eq("ss_end", 32'(SS), 32'({NSS{1'b1}}));
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; LsbFirst = 1'b0; TxValid = 1'b0;
      SlaveSel = '0; Mode = 2'd0; ClkDiv = '0; BurstLen = '0; TxData = '0;
      fill_random();
      repeat (3) @(posedge Clk); #1;
      check_eq("rst_ss", 32'(SS), 32'({NSS{1'b1}}));
      check_eq("rst_sclk", 32'(SClk), 0);
      check_eq("rst_mosi", 32'(MOSI), 0);
      check_eq("rst_txready", 32'(TxReady), 0);
      check_eq("rst_rxvalid", 32'(RxValid), 0);
      check_eq("rst_rxdata", 32'(RxData), 0);
      check_eq("rst_busy", 32'(Busy), 0);
      check_eq("rst_done", 32'(Done), 0);
      Reset = 1'b0;

      // Mode 3, single word A5 with slave answering D6.
      tx_arr[0] = 8'hA5; resp_arr[0] = 8'hD6;
      run_burst(0, 3, 0, 1, 1, 0, 0);

      // All modes and both bit orders.
      for (int m = 0; m < 4; m++) begin
         for (int l = 0; l < 2; l++) begin
            tx_arr[0] = 8'h3C; resp_arr[0] = 8'hC3;
            run_burst($urandom_range(0, 3), m, l, $urandom_range(0, 2), 1, 0, 0);
         end
      end

      // Four-word burst with TxValid held high and a Start poke while busy.
      fill_random();
      tx_arr[0] = 8'h11; tx_arr[1] = 8'h22; tx_arr[2] = 8'h33; tx_arr[3] = 8'h44;
      run_burst(2, 0, 0, 1, 4, 0, 1);

      // Three-word burst, first gap stalled 20 cycles.
      fill_random();
      run_burst(1, 2, 1, 1, 3, 20, 0);

      // Reset in the middle of a two-word transfer.
      fill_random();
      setup_cfg(1, 1, 0, 1, 2);
      @(posedge Clk); #1;
      Start = 1'b1; TxData = tx_arr[0];
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int c = 0; c < 400 && pulses < 3; c++) @(negedge Clk);
      check_eq("reset_reach_xfer", 32'(pulses >= 3), 1);
      @(posedge Clk); #1 Reset = 1'b1;
      @(posedge Clk); #1;
      check_eq("abort_ss", 32'(SS), 32'({NSS{1'b1}}));
      check_eq("abort_busy", 32'(Busy), 0);
      Reset = 1'b0;
      repeat (30) @(negedge Clk);
      check_eq("abort_done", done_cnt, 0);
      check_eq("abort_rxvalid", rxv_cnt, 0);
      run_burst(3, 0, 1, 0, 2, 0, 0);

      // Out-of-range slave selects are ignored.
      for (int s = 4; s < 6; s++) begin
         setup_cfg(s, 0, 0, 0, 1);
         @(posedge Clk); #1 Start = 1'b1;
         @(posedge Clk); #1 Start = 1'b0;
         repeat (30) @(negedge Clk);
         check_eq($sformatf("badsel%0d_busy", s), busy_cnt, 0);
         check_eq($sformatf("badsel%0d_done", s), done_cnt, 0);
         check_eq($sformatf("badsel%0d_ss", s), ss_fall, 0);
      end

      // Randomized bursts, including BurstLen 0.
      for (int r = 0; r < 6; r++) begin
         fill_random();
         run_burst($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 5), 0);
      end

      // Largest divider, then the longest burst.
      fill_random();
      run_burst(0, 1, 0, 15, 2, 0, 0);
      fill_random();
      run_burst(2, 3, 1, 0, 255, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
